// File: rtl/gen_fifo_async_rdctl_pkg.sv
// gen_fifo_async_rdctl_pkg
// Shared constants for the asynchronous FIFO read-side controller.
// No ports; imported by the controller, its synchronizer and its interface.
package gen_fifo_async_rdctl_pkg;

   // Number of flops the write pointer crosses before it is used in rclk.
   localparam int SYNC_STAGES = 2;

   // Value of the empty flag while the controller is held in reset.
   localparam logic EMPTY_AT_RESET = 1'b1;

   // Value of the sticky underflow flag after reset.
   localparam logic UNDERFLOW_AT_RESET = 1'b0;

endpackage

// File: rtl/gen_fifo_async_rdctl_if.sv
// gen_fifo_async_rdctl_if
// Consumer / RAM-read-port side of the asynchronous FIFO read controller.
//   pop                  consumer read request (consumer -> controller)
//   far_depth            registered depth as seen in the read clock domain
//   far_empty            registered empty flag
//   far_underflow        sticky "pop while empty" flag
//   far_ram_read_addr    binary RAM read address
//   far_ram_read_strobe  RAM read enable, combinational from pop
// Modports: master = consumer side, slave = read controller.
interface gen_fifo_async_rdctl_if #(
   parameter int PTR_WIDTH = 1
);
   logic                 pop;
   logic [PTR_WIDTH:0]   far_depth;
   logic                 far_empty;
   logic                 far_underflow;
   logic [PTR_WIDTH-1:0] far_ram_read_addr;
   logic                 far_ram_read_strobe;

   modport master (
      output pop,
      input  far_depth,
      input  far_empty,
      input  far_underflow,
      input  far_ram_read_addr,
      input  far_ram_read_strobe
   );

   modport slave (
      input  pop,
      output far_depth,
      output far_empty,
      output far_underflow,
      output far_ram_read_addr,
      output far_ram_read_strobe
   );
endinterface

// File: rtl/gen_fifo_async_rdctl_sync2_sreset.sv
// gen_fifo_async_rdctl_sync2_sreset
// Two-flop synchronizer with synchronous active-high reset, used to bring
// the gray-coded write pointer into the read clock domain. Gray coding
// upstream guarantees at most one bit changes per write, so a per-bit
// synchronizer yields either the old or the new pointer value.
//   clk   destination clock
//   srst  synchronous active-high reset, clears both stages to 0
//   d     asynchronous input bus
//   q     synchronized output (second stage)
module gen_fifo_async_rdctl_sync2_sreset
   import gen_fifo_async_rdctl_pkg::*;
#(
   parameter int WIDTH = 2
) (
   input  logic             clk,
   input  logic             srst,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   // stage_reg[0] is the metastability-catching flop, the last stage feeds q.
   logic [WIDTH-1:0] stage_reg [SYNC_STAGES];

   always_ff @(posedge clk) begin
      if (srst) begin
         for (int i = 0; i < SYNC_STAGES; i++) begin
            stage_reg[i] <= '0;
         end
      end else begin
         stage_reg[0] <= d;
         for (int i = 1; i < SYNC_STAGES; i++) begin
            stage_reg[i] <= stage_reg[i-1];
         end
      end
   end

   assign q = stage_reg[SYNC_STAGES-1];

endmodule

// File: rtl/gen_fifo_async_rdctl.sv
// gen_fifo_async_rdctl
// Read-side controller of the generic asynchronous FIFO; everything runs on
// rclk. The write controller's gray pointer is synchronized, converted to
// binary and compared with the local read pointer to produce depth/empty.
// Pops are qualified against the registered empty flag so the RAM is never
// read past the last valid entry.
//   rclk                 read clock
//   rreset               synchronous active-high reset
//   rusable              synchronized write pointer may be trusted
//   faw_write_addr_gray  gray write pointer from the write domain (async)
//   far_read_addr_gray   registered gray read pointer, to the write side
//   rd                   consumer / RAM interface (slave modport)
module gen_fifo_async_rdctl
   import gen_fifo_async_rdctl_pkg::*;
#(
   parameter int PTR_WIDTH = 1
) (
   input  logic                 rclk,
   input  logic                 rreset,
   input  logic                 rusable,
   input  logic [PTR_WIDTH:0]   faw_write_addr_gray,
   output logic [PTR_WIDTH:0]   far_read_addr_gray,
   gen_fifo_async_rdctl_if.slave rd
);

   localparam logic [PTR_WIDTH:0] DEPTH_EMPTY = '0;

   logic [PTR_WIDTH:0] wr_gray_d2;
   logic [PTR_WIDTH:0] wr_bin_d2;
   logic [PTR_WIDTH:0] wr_eff;
   logic [PTR_WIDTH:0] gap;
   logic [PTR_WIDTH:0] depth_next;
   logic [PTR_WIDTH:0] rd_bin_next;
   logic [PTR_WIDTH:0] rd_gray_next;
   logic [PTR_WIDTH:0] pop_ext;

   logic [PTR_WIDTH:0] rd_bin_reg;
   logic [PTR_WIDTH:0] rd_gray_reg;
   logic [PTR_WIDTH:0] depth_reg;
   logic               empty_reg;
   logic               underflow_reg;
   logic               pop_final;

   gen_fifo_async_rdctl_sync2_sreset #(
      .WIDTH (PTR_WIDTH + 1)
   ) u_wr_sync (
      .clk  (rclk),
      .srst (rreset),
      .d    (faw_write_addr_gray),
      .q    (wr_gray_d2)
   );

   // Gray to binary: each binary bit is the XOR of all gray bits at or
   // above it. Written per bit to avoid a bit-level feedback chain.
   generate
      for (genvar gi = 0; gi <= PTR_WIDTH; gi++) begin : g_gray2bin
         assign wr_bin_d2[gi] = ^wr_gray_d2[PTR_WIDTH:gi];
      end
   endgenerate

   // Pops against the registered empty flag; dropped pops only raise underflow.
   assign pop_final = rd.pop & ~empty_reg & ~rreset;
   assign pop_ext   = {{PTR_WIDTH{1'b0}}, pop_final};

   // With an untrusted write pointer, pretend the writer is exactly where
   // the reader is: the FIFO looks empty and no pop can be qualified.
   assign wr_eff = rusable ? wr_bin_d2 : rd_bin_reg;

   // Modulo arithmetic at PTR_WIDTH+1 bits keeps the depth right across
   // pointer wrap; the extra MSB distinguishes full from empty.
   assign gap          = wr_eff - rd_bin_reg;
   assign depth_next   = gap - pop_ext;
   assign rd_bin_next  = rd_bin_reg + pop_ext;
   assign rd_gray_next = rd_bin_next ^ (rd_bin_next >> 1);

   always_ff @(posedge rclk) begin
      if (rreset) begin
         rd_bin_reg    <= '0;
         rd_gray_reg   <= '0;
         depth_reg     <= DEPTH_EMPTY;
         empty_reg     <= EMPTY_AT_RESET;
         underflow_reg <= UNDERFLOW_AT_RESET;
      end else begin
         rd_bin_reg <= rd_bin_next;
         if (pop_final) begin
            rd_gray_reg <= rd_gray_next;
         end
         depth_reg <= depth_next;
         empty_reg <= (depth_next == DEPTH_EMPTY);
         if (rd.pop && empty_reg) begin
            underflow_reg <= 1'b1;
         end
      end
   end

   assign far_read_addr_gray     = rd_gray_reg;
   assign rd.far_depth           = depth_reg;
   assign rd.far_empty           = empty_reg;
   assign rd.far_underflow       = underflow_reg;
   assign rd.far_ram_read_addr   = rd_bin_reg[PTR_WIDTH-1:0];
   assign rd.far_ram_read_strobe = pop_final;

endmodule

// File: tb/tb_gen_fifo_async_rdctl.sv
// tb_gen_fifo_async_rdctl
// Drives the read controller with directed scenarios and a randomized
// write/pop stream. A reference model tracks writes and reads as plain
// integer counters (mod 2^(PW+1)) with a two-sample visibility delay for the
// write count; a negedge process compares every output against it, and the
// directed scenarios add literal expectations.
module tb_gen_fifo_async_rdctl;

   localparam int PW   = 2;
   localparam int MASK = (1 << (PW + 1)) - 1;
   localparam int CAP  = 1 << PW;

   logic          rclk = 1'b0;
   logic          rreset;
   logic          rusable;
   logic [PW:0]   faw;
   logic [PW:0]   far_gray;

   gen_fifo_async_rdctl_if #(.PTR_WIDTH(PW)) rd_if ();

   gen_fifo_async_rdctl #(.PTR_WIDTH(PW)) dut (
      .rclk                (rclk),
      .rreset              (rreset),
      .rusable             (rusable),
      .faw_write_addr_gray (faw),
      .far_read_addr_gray  (far_gray),
      .rd                  (rd_if)
   );

   always #5 rclk = ~rclk;

   int tests = 0;
   int fails = 0;
   int wcount = 0;
   int reads_seen = 0;
   int wraps_seen = 0;

   // Model state: values the registered outputs must hold after the most
   // recent rising edge.
   int m_rd = 0;
   int m_depth = 0;
   bit m_empty = 1'b1;
   bit m_uf = 1'b0;
   int m_vis1 = 0;   // write count sampled at the last edge
   int m_vis2 = 0;   // write count sampled one edge before that
   bit m_valid = 1'b0;

   task automatic check(input string name, input int act, input int exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic set_w(input int c);
      wcount = c & MASK;
      faw    = (PW + 1)'(wcount ^ (wcount >> 1));
   endtask

   // Advance n rising edges, then settle 1 time unit past the last one.
   task automatic step(input int n);
      repeat (n) @(posedge rclk);
      #1;
   endtask

   // Reference model and per-cycle comparison. Inputs are changed just after
   // rising edges, so at the falling edge they are the values the next
   // rising edge will sample.
   initial begin
      forever begin
         @(negedge rclk);
         if (m_valid) begin
            bit exp_strobe;
            exp_strobe = rd_if.pop && !m_empty && !rreset;
            check("depth",     int'(rd_if.far_depth),           m_depth);
            check("empty",     int'(rd_if.far_empty),           int'(m_empty));
            check("underflow", int'(rd_if.far_underflow),       int'(m_uf));
            check("gray",      int'(far_gray),                  (m_rd ^ (m_rd >> 1)) & MASK);
            check("ram_addr",  int'(rd_if.far_ram_read_addr),   m_rd % CAP);
            check("strobe",    int'(rd_if.far_ram_read_strobe), int'(exp_strobe));
            if (exp_strobe) begin
               reads_seen++;
               if ((m_rd % CAP) == CAP - 1) wraps_seen++;
               $display("[TB] t=%0t read addr=%0d depth=%0d", $time, m_rd % CAP, m_depth);
            end
         end
         if (rreset) begin
            m_rd    = 0;
            m_depth = 0;
            m_empty = 1'b1;
            m_uf    = 1'b0;
            m_vis1  = 0;
            m_vis2  = 0;
            m_valid = 1'b1;
         end else begin
            int taken;
            int writer;
            taken  = (rd_if.pop && !m_empty) ? 1 : 0;
            writer = rusable ? m_vis2 : m_rd;
            if (rd_if.pop && m_empty) m_uf = 1'b1;
            m_depth = (writer - m_rd - taken) & MASK;
            m_empty = (m_depth == 0);
            m_rd    = (m_rd + taken) & MASK;
            m_vis2  = m_vis1;
            m_vis1  = wcount;
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      // 1. Reset with pop held high.
      rreset = 1'b1;
      rusable = 1'b1;
      rd_if.pop = 1'b1;
      set_w(0);
      step(1);
      check("rst_strobe1", int'(rd_if.far_ram_read_strobe), 0);
      step(1);
      check("rst_empty", int'(rd_if.far_empty), 1);
      check("rst_depth", int'(rd_if.far_depth), 0);
      check("rst_gray", int'(far_gray), 0);
      check("rst_strobe2", int'(rd_if.far_ram_read_strobe), 0);
      check("rst_uf", int'(rd_if.far_underflow), 0);

      // 2. Fill to 3 then drain.
      rreset = 1'b0;
      rd_if.pop = 1'b0;
      set_w(3);
      step(2);
      check("fill_latency_depth", int'(rd_if.far_depth), 0);
      step(1);
      check("fill_depth", int'(rd_if.far_depth), 3);
      check("fill_empty", int'(rd_if.far_empty), 0);
      rd_if.pop = 1'b1;
      #1;
      check("pop0_strobe", int'(rd_if.far_ram_read_strobe), 1);
      check("pop0_addr", int'(rd_if.far_ram_read_addr), 0);
      step(1);
      check("pop1_depth", int'(rd_if.far_depth), 2);
      check("pop1_addr", int'(rd_if.far_ram_read_addr), 1);
      step(1);
      check("pop2_depth", int'(rd_if.far_depth), 1);
      check("pop2_addr", int'(rd_if.far_ram_read_addr), 2);
      step(1);
      check("drain_depth", int'(rd_if.far_depth), 0);
      check("drain_empty", int'(rd_if.far_empty), 1);
      check("drain_gray", int'(far_gray), 2);
      check("pop4_strobe", int'(rd_if.far_ram_read_strobe), 0);

      // 3. Underflow from the dropped 4th pop; sticky until reset.
      step(1);
      check("uf_set", int'(rd_if.far_underflow), 1);
      check("uf_addr_hold", int'(rd_if.far_ram_read_addr), 3);
      rd_if.pop = 1'b0;
      step(5);
      check("uf_sticky", int'(rd_if.far_underflow), 1);
      rreset = 1'b1;
      set_w(0);
      step(1);
      check("uf_cleared", int'(rd_if.far_underflow), 0);
      rreset = 1'b0;

      // 4. Random stream of writes and pops across several pointer wraps.
      for (int i = 0; i < 160; i++) begin
         if ((((wcount - m_rd) & MASK) < CAP) && ($urandom_range(0, 1) == 1))
            set_w(wcount + 1);
         rd_if.pop = ($urandom_range(0, 2) != 0);
         step(1);
      end
      rd_if.pop = 1'b1;
      step(12);
      check("rand_drained_empty", int'(rd_if.far_empty), 1);
      check("rand_drained_depth", int'(rd_if.far_depth), 0);
      check("rand_reads_ge10", int'(reads_seen >= 10), 1);
      check("rand_addr_wrapped", int'(wraps_seen > 0), 1);
      rd_if.pop = 1'b0;

      // 5. Pop and new write visible in the same cycle.
      rreset = 1'b1;
      set_w(0);
      step(1);
      rreset = 1'b0;
      set_w(2);
      step(3);
      check("sim_depth_before", int'(rd_if.far_depth), 2);
      set_w(3);
      step(2);
      rd_if.pop = 1'b1;
      #1;
      check("sim_strobe", int'(rd_if.far_ram_read_strobe), 1);
      check("sim_addr", int'(rd_if.far_ram_read_addr), 0);
      step(1);
      rd_if.pop = 1'b0;
      check("sim_depth_after", int'(rd_if.far_depth), 2);
      check("sim_addr_after", int'(rd_if.far_ram_read_addr), 1);

      // 6. rusable gating, then reset in the middle of a pop burst.
      rreset = 1'b1;
      set_w(0);
      step(1);
      rreset = 1'b0;
      rusable = 1'b0;
      set_w(4);
      step(4);
      check("unusable_depth", int'(rd_if.far_depth), 0);
      check("unusable_empty", int'(rd_if.far_empty), 1);
      rd_if.pop = 1'b1;
      #1;
      check("unusable_strobe", int'(rd_if.far_ram_read_strobe), 0);
      step(1);
      rd_if.pop = 1'b0;
      check("unusable_addr", int'(rd_if.far_ram_read_addr), 0);
      rusable = 1'b1;
      step(1);
      check("usable_depth", int'(rd_if.far_depth), 4);
      check("usable_empty", int'(rd_if.far_empty), 0);
      rd_if.pop = 1'b1;
      step(2);
      check("burst_depth", int'(rd_if.far_depth), 2);
      check("burst_addr", int'(rd_if.far_ram_read_addr), 2);
      rreset = 1'b1;
      #1;
      check("midrst_strobe", int'(rd_if.far_ram_read_strobe), 0);
      set_w(0);
      step(1);
      check("midrst_depth", int'(rd_if.far_depth), 0);
      check("midrst_empty", int'(rd_if.far_empty), 1);
      check("midrst_gray", int'(far_gray), 0);
      check("midrst_addr", int'(rd_if.far_ram_read_addr), 0);
      check("midrst_uf", int'(rd_if.far_underflow), 0);
      rreset = 1'b0;
      rd_if.pop = 1'b0;
      step(3);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
